// File: rtl/exec_pkg.sv
// Shared definitions for the NTP execution stage: opcodes, flag bit positions
// and the sequencing state encoding.
package exec_pkg;

  localparam logic [31:0] OP_NOP   = 32'd0;
  localparam logic [31:0] OP_ADD   = 32'd1;
  localparam logic [31:0] OP_ADC   = 32'd2;
  localparam logic [31:0] OP_SUB   = 32'd3;
  localparam logic [31:0] OP_SBB   = 32'd4;
  localparam logic [31:0] OP_AND   = 32'd5;
  localparam logic [31:0] OP_OR    = 32'd6;
  localparam logic [31:0] OP_XOR   = 32'd7;
  localparam logic [31:0] OP_NOT   = 32'd8;
  localparam logic [31:0] OP_SHL   = 32'd9;
  localparam logic [31:0] OP_SHR   = 32'd10;
  localparam logic [31:0] OP_ROL   = 32'd11;
  localparam logic [31:0] OP_ROR   = 32'd12;
  localparam logic [31:0] OP_INC   = 32'd13;
  localparam logic [31:0] OP_DEC   = 32'd14;
  localparam logic [31:0] OP_CMP   = 32'd15;
  localparam logic [31:0] OP_MOVB  = 32'd16;
  localparam logic [31:0] OP_IN    = 32'd17;
  localparam logic [31:0] OP_OUT   = 32'd18;
  localparam logic [31:0] OP_STORE = 32'd19;
  localparam logic [31:0] OP_MUL   = 32'd20;

  // Flag vector is {V,S,Z,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } exec_state_t;

endpackage

// File: rtl/exec_unit_pipe_seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle, DATA_W cycles.
// 'product' shows the accumulator value being written on the cycle 'done' is high.
module seq_multiplier #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [CNT_W-1:0]  r_count;
  logic              r_busy;
  logic [DATA_W:0]   w_sum;

  // Multiplier bits are consumed from r_lo while product bits shift in from the top
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (start && !r_busy) begin
      r_mcand <= a;
      r_hi    <= '0;
      r_lo    <= b;
      r_count <= CNT_W'(DATA_W - 1);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_hi <= w_sum[DATA_W:1];
      r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_count == '0);
  assign product = {w_sum[DATA_W:1], w_sum[0], r_lo[DATA_W-1:1]};

endmodule

// File: rtl/exec_unit_pipe.sv
// Handshaked NTP execution stage: single-cycle ALU ops plus an iterative
// multiplier, with registered result, flags, memory write data and port data.
module exec_unit_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 5,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op_dec,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] ans_ex,
  output logic [DATA_W-1:0] ans_hi,
  output logic [DATA_W-1:0] DM_data,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        flag_ex,
  output logic              out_valid
);

  localparam int MSB = DATA_W - 1;

  exec_state_t r_state, w_stateNext;

  logic [DATA_W-1:0]   r_ansEx, r_ansHi, r_dmData, r_dataOut;
  logic [3:0]          r_flags;
  logic                r_outValid;

  logic [31:0]         w_op;
  logic                w_accept, w_mulOp, w_startMul, w_mulBusy, w_mulDone;
  logic [2*DATA_W-1:0] w_product;
  logic                w_arith, w_sub, w_useCin;
  logic [DATA_W-1:0]   w_bOp;
  logic [DATA_W:0]     w_cin, w_sum;
  logic [DATA_W-1:0]   w_res;
  logic                w_c, w_v;
  logic                w_updAns, w_updFlags, w_updOut, w_updDm;
  logic [3:0]          w_flagsNew, w_mulFlags;

  assign w_op       = 32'(op_dec);
  assign in_ready   = (r_state == ST_IDLE) && !w_mulBusy;
  assign w_accept   = in_valid && in_ready;
  assign w_mulOp    = (MUL_EN != 0) && (w_op == OP_MUL);
  assign w_startMul = w_accept && w_mulOp;

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_startMul),
    .a       (A),
    .b       (B),
    .busy    (w_mulBusy),
    .done    (w_mulDone),
    .product (w_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:     if (w_startMul) w_stateNext = ST_MUL_BUSY;
      ST_MUL_BUSY: if (w_mulDone)  w_stateNext = ST_IDLE;
      default:     w_stateNext = ST_IDLE;
    endcase
  end

  // One shared adder/subtractor; INC/DEC reuse it with a constant one
  always_comb begin
    w_arith  = 1'b0;
    w_sub    = 1'b0;
    w_useCin = 1'b0;
    w_bOp    = B;
    case (w_op)
      OP_ADD:         w_arith = 1'b1;
      OP_ADC:         begin w_arith = 1'b1; w_useCin = 1'b1; end
      OP_SUB, OP_CMP: begin w_arith = 1'b1; w_sub = 1'b1; end
      OP_SBB:         begin w_arith = 1'b1; w_sub = 1'b1; w_useCin = 1'b1; end
      OP_INC:         begin w_arith = 1'b1; w_bOp = DATA_W'(1); end
      OP_DEC:         begin w_arith = 1'b1; w_sub = 1'b1; w_bOp = DATA_W'(1); end
      default:        ;
    endcase
  end

  assign w_cin = {{DATA_W{1'b0}}, w_useCin & r_flags[FLAG_C]};
  assign w_sum = w_sub ? ({1'b0, A} - {1'b0, w_bOp} - w_cin)
                       : ({1'b0, A} + {1'b0, w_bOp} + w_cin);

  always_comb begin
    w_res      = w_sum[MSB:0];
    w_c        = w_sum[DATA_W];
    w_updAns   = 1'b0;
    w_updFlags = 1'b0;
    w_updOut   = 1'b0;
    w_updDm    = 1'b0;
    case (w_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC: begin
        w_updAns = 1'b1; w_updFlags = 1'b1;
      end
      OP_CMP:   w_updFlags = 1'b1;
      OP_AND:   begin w_res = A & B; w_c = 1'b0; w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_OR:    begin w_res = A | B; w_c = 1'b0; w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_XOR:   begin w_res = A ^ B; w_c = 1'b0; w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_NOT:   begin w_res = ~A;    w_c = 1'b0; w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_SHL:   begin w_res = {A[MSB-1:0], 1'b0}; w_c = A[MSB]; w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_SHR:   begin w_res = {1'b0, A[MSB:1]};   w_c = A[0];   w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_ROL:   begin w_res = {A[MSB-1:0], A[MSB]}; w_c = A[MSB]; w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_ROR:   begin w_res = {A[0], A[MSB:1]};     w_c = A[0];   w_updAns = 1'b1; w_updFlags = 1'b1; end
      OP_MOVB:  begin w_res = B;       w_updAns = 1'b1; end
      OP_IN:    begin w_res = data_in; w_updAns = 1'b1; end
      OP_OUT:   w_updOut = 1'b1;
      OP_STORE: w_updDm  = 1'b1;
      default:  ;
    endcase
  end

  assign w_v = w_arith
             && (w_sub ? (A[MSB] != w_bOp[MSB]) : (A[MSB] == w_bOp[MSB]))
             && (w_res[MSB] != A[MSB]);

  assign w_flagsNew = {w_v, w_res[MSB], (w_res == '0), w_c};
  assign w_mulFlags = {1'b0, w_product[2*DATA_W-1], (w_product == '0), 1'b0};

  // A MUL acceptance itself updates nothing; its results land when the multiplier finishes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ansEx    <= '0;
      r_ansHi    <= '0;
      r_dmData   <= '0;
      r_dataOut  <= '0;
      r_flags    <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (w_mulDone) begin
        r_ansHi    <= w_product[2*DATA_W-1:DATA_W];
        r_ansEx    <= w_product[DATA_W-1:0];
        r_flags    <= w_mulFlags;
        r_outValid <= 1'b1;
      end else if (w_accept && !w_mulOp) begin
        r_outValid <= 1'b1;
        if (w_updAns)   r_ansEx   <= w_res;
        if (w_updFlags) r_flags   <= w_flagsNew;
        if (w_updOut)   r_dataOut <= A;
        if (w_updDm)    r_dmData  <= B;
      end
    end
  end

  assign ans_ex    = r_ansEx;
  assign ans_hi    = r_ansHi;
  assign DM_data   = r_dmData;
  assign data_out  = r_dataOut;
  assign flag_ex   = r_flags;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed self-checking bench: an 8-bit and a 16-bit instance share the clock,
// reset and operand buses; each vector targets one of them.
module tb_exec_unit_pipe;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid8, inValid16;
  logic [4:0]  opDec;
  logic [15:0] aBus, bBus, dataIn;

  logic        inReady8, outValid8;
  logic [7:0]  ansEx8, ansHi8, dmData8, dataOut8;
  logic [3:0]  flag8;
  logic        inReady16, outValid16;
  logic [15:0] ansEx16, ansHi16, dmData16, dataOut16;
  logic [3:0]  flag16;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  exec_unit_pipe #(.DATA_W(8), .OP_W(5), .MUL_EN(1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(inValid8), .in_ready(inReady8),
    .op_dec(opDec), .A(aBus[7:0]), .B(bBus[7:0]), .data_in(dataIn[7:0]),
    .ans_ex(ansEx8), .ans_hi(ansHi8), .DM_data(dmData8), .data_out(dataOut8),
    .flag_ex(flag8), .out_valid(outValid8)
  );

  exec_unit_pipe #(.DATA_W(16), .OP_W(5), .MUL_EN(1)) dut16 (
    .clk(clk), .reset(reset), .in_valid(inValid16), .in_ready(inReady16),
    .op_dec(opDec), .A(aBus), .B(bBus), .data_in(dataIn),
    .ans_ex(ansEx16), .ans_hi(ansHi16), .DM_data(dmData16), .data_out(dataOut16),
    .flag_ex(flag16), .out_valid(outValid16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one vector for exactly one accepting edge, then returns #1 after that edge
  task automatic applyStimulus(input logic sel16, input logic [31:0] op,
                               input logic [15:0] a, input logic [15:0] b, input logic [15:0] din);
    @(negedge clk);
    opDec     = op[4:0];
    aBus      = a;
    bBus      = b;
    dataIn    = din;
    inValid8  = !sel16;
    inValid16 = sel16;
    @(posedge clk);
    #1;
    inValid8  = 1'b0;
    inValid16 = 1'b0;
  endtask

  task automatic waitMulDone(input logic sel16, input int expCycles, input string tag);
    int   cycles   = 0;
    int   lowReady = 0;
    logic seen     = 1'b0;
    while (!seen && cycles < 100) begin
      if (sel16 ? outValid16 : outValid8) begin
        seen = 1'b1;
      end else begin
        if (!(sel16 ? inReady16 : inReady8)) lowReady++;
        if (cycles == 2) begin
          opDec = 5'd1;
          if (sel16) inValid16 = 1'b1; else inValid8 = 1'b1;
        end
        if (cycles == 3) begin
          inValid8  = 1'b0;
          inValid16 = 1'b0;
        end
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    inValid8  = 1'b0;
    inValid16 = 1'b0;
    checkOutput({tag, "_done"}, 32'(seen), 32'h1);
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'(expCycles));
    checkOutput({tag, "_readyLow"}, 32'(lowReady), 32'(expCycles));
    checkOutput({tag, "_readyAtDone"}, 32'(sel16 ? inReady16 : inReady8), 32'h1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    reset = 1'b1; inValid8 = 1'b0; inValid16 = 1'b0;
    opDec = 5'd0; aBus = '0; bBus = '0; dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ans8",   32'(ansEx8),   32'h0);
    checkOutput("rst_hi8",    32'(ansHi8),   32'h0);
    checkOutput("rst_flag8",  32'(flag8),    32'h0);
    checkOutput("rst_dm8",    32'(dmData8),  32'h0);
    checkOutput("rst_out8",   32'(dataOut8), 32'h0);
    checkOutput("rst_ready8", 32'(inReady8), 32'h1);
    checkOutput("rst_valid8", 32'(outValid8), 32'h0);
    checkOutput("rst_ready16", 32'(inReady16), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, OP_ADD, 16'h007F, 16'h0001, 16'h0000);
    checkOutput("add_ovf_ans",   32'(ansEx8),    32'h80);
    checkOutput("add_ovf_flag",  32'(flag8),     32'hC);
    checkOutput("add_ovf_valid", 32'(outValid8), 32'h1);
    @(posedge clk); #1;
    checkOutput("add_ovf_validDrop", 32'(outValid8), 32'h0);

    applyStimulus(1'b0, OP_ADD, 16'h00FF, 16'h0001, 16'h0000);
    checkOutput("add_wrap_ans",  32'(ansEx8), 32'h00);
    checkOutput("add_wrap_flag", 32'(flag8),  32'h3);
    applyStimulus(1'b0, OP_ADC, 16'h0000, 16'h0000, 16'h0000);
    checkOutput("adc_ans",  32'(ansEx8), 32'h01);
    checkOutput("adc_flag", 32'(flag8),  32'h0);

    applyStimulus(1'b0, OP_MUL, 16'h00FF, 16'h00FF, 16'h0000);
    waitMulDone(1'b0, 8, "mul8");
    checkOutput("mul8_hi",   32'(ansHi8), 32'hFE);
    checkOutput("mul8_lo",   32'(ansEx8), 32'h01);
    checkOutput("mul8_flag", 32'(flag8),  32'h4);
    @(posedge clk); #1;
    checkOutput("mul8_noExtraValid", 32'(outValid8), 32'h0);
    checkOutput("mul8_ansHeld",      32'(ansEx8),    32'h01);

    applyStimulus(1'b0, OP_CMP, 16'h0003, 16'h0005, 16'h0000);
    checkOutput("cmp_lt_ans",  32'(ansEx8), 32'h01);
    checkOutput("cmp_lt_flag", 32'(flag8),  32'h5);
    applyStimulus(1'b0, OP_CMP, 16'h0005, 16'h0005, 16'h0000);
    checkOutput("cmp_eq_flag", 32'(flag8),  32'h2);

    applyStimulus(1'b0, OP_OUT, 16'h005A, 16'h0000, 16'h0000);
    checkOutput("out_data", 32'(dataOut8), 32'h5A);
    checkOutput("out_ans",  32'(ansEx8),   32'h01);
    applyStimulus(1'b0, OP_STORE, 16'h0000, 16'h00C3, 16'h0000);
    checkOutput("store_dm", 32'(dmData8), 32'hC3);
    applyStimulus(1'b0, OP_IN, 16'h0000, 16'h0000, 16'h0011);
    checkOutput("in_ans",  32'(ansEx8), 32'h11);
    checkOutput("in_flag", 32'(flag8),  32'h2);

    applyStimulus(1'b0, OP_INC, 16'h00FF, 16'h0000, 16'h0000);
    checkOutput("inc_wrap_ans",  32'(ansEx8), 32'h00);
    checkOutput("inc_wrap_flag", 32'(flag8),  32'h3);
    applyStimulus(1'b0, OP_DEC, 16'h0000, 16'h0000, 16'h0000);
    checkOutput("dec_wrap_ans",  32'(ansEx8), 32'hFF);
    checkOutput("dec_wrap_flag", 32'(flag8),  32'h5);
    applyStimulus(1'b0, OP_SHL, 16'h0081, 16'h0000, 16'h0000);
    checkOutput("shl_ans",  32'(ansEx8), 32'h02);
    checkOutput("shl_flag", 32'(flag8),  32'h1);
    applyStimulus(1'b0, OP_XOR, 16'h00A5, 16'h00FF, 16'h0000);
    checkOutput("xor_ans",  32'(ansEx8), 32'h5A);
    checkOutput("xor_flag", 32'(flag8),  32'h0);

    applyStimulus(1'b0, OP_MUL, 16'h0000, 16'h0037, 16'h0000);
    waitMulDone(1'b0, 8, "mulz8");
    checkOutput("mulz8_flag", 32'(flag8), 32'h2);

    applyStimulus(1'b0, OP_MUL, 16'h0003, 16'h0005, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmul_ans",   32'(ansEx8),    32'h0);
    checkOutput("rstmul_hi",    32'(ansHi8),    32'h0);
    checkOutput("rstmul_flag",  32'(flag8),     32'h0);
    checkOutput("rstmul_dm",    32'(dmData8),   32'h0);
    checkOutput("rstmul_out",   32'(dataOut8),  32'h0);
    checkOutput("rstmul_ready", 32'(inReady8),  32'h1);
    checkOutput("rstmul_valid", 32'(outValid8), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (outValid8) pulses++;
    end
    checkOutput("rstmul_noValid", 32'(pulses), 32'h0);
    checkOutput("rstmul_readyAfter", 32'(inReady8), 32'h1);

    applyStimulus(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 16'h0000);
    checkOutput("add16_ans",   32'(ansEx16),    32'h8000);
    checkOutput("add16_flag",  32'(flag16),     32'hC);
    checkOutput("add16_valid", 32'(outValid16), 32'h1);
    applyStimulus(1'b1, OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0000);
    waitMulDone(1'b1, 16, "mul16");
    checkOutput("mul16_hi",   32'(ansHi16), 32'hFFFE);
    checkOutput("mul16_lo",   32'(ansEx16), 32'h0001);
    checkOutput("mul16_flag", 32'(flag16),  32'h4);
    applyStimulus(1'b1, OP_MUL, 16'h1234, 16'h0010, 16'h0000);
    waitMulDone(1'b1, 16, "mul16b");
    checkOutput("mul16b_hi",   32'(ansHi16), 32'h0001);
    checkOutput("mul16b_lo",   32'(ansEx16), 32'h2340);
    checkOutput("mul16b_flag", 32'(flag16),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/exec_unit_pipe.md
Name: exec_unit_pipe

Overview:
Parametrised, handshaked execution stage for the NTP datapath; successor to the fixed 8-bit ALU-plus-register execution stage. Takes decoded op and operands from decode, computes in one cycle or iteratively (multiply), and registers the result, flags, data-memory write data and output-port data. Adds valid/ready flow control, carry-chained arithmetic and a multi-cycle shift-add multiplier the 8-bit stage lacks.

Parameters:
DATA_W, 8, operand/result width (>=4)
OP_W, 5, opcode width
MUL_EN, 1, 1 = MUL supported; 0 = MUL behaves as NOP

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  op/operands present
in_ready  out  1  stage can accept (low while multiplier busy)
op_dec  in  OP_W  decoded opcode
A  in  DATA_W  operand A
B  in  DATA_W  operand B
data_in  in  DATA_W  input-port data
ans_ex  out  DATA_W  registered result (low half for MUL)
ans_hi  out  DATA_W  registered MUL high half
DM_data  out  DATA_W  registered data-memory write data
data_out  out  DATA_W  registered output-port data
flag_ex  out  4  {V,S,Z,C} = [3:0]
out_valid  out  1  one-cycle pulse: result registers updated

Behaviour:
- Reset (sync): all outputs 0, flags 0, in_ready=1, state IDLE; an in-flight MUL is abandoned, no out_valid.
- Accept = in_valid & in_ready at a rising edge.
- FSM: IDLE -> IDLE on single-cycle op; IDLE -> MUL_BUSY on accepted MUL (MUL_EN=1); MUL_BUSY stays DATA_W cycles (counter DATA_W-1..0), -> IDLE on count 0.
- Single-cycle latency: ans_ex/flags/out_valid update the edge of acceptance; out_valid high the following cycle only.
- MUL: unsigned shift-add, one partial product per cycle; {ans_hi,ans_ex} and out_valid updated DATA_W cycles after accept; in_ready=0 throughout MUL_BUSY, asserted the cycle out_valid is high.
- Ops (codes in package): NOP 0, ADD 1, ADC 2, SUB 3, SBB 4, AND 5, OR 6, XOR 7, NOT 8 (~A), SHL 9, SHR 10, ROL 11, ROR 12, INC 13, DEC 14, CMP 15, MOVB 16, IN 17, OUT 18, STORE 19, MUL 20; other codes = NOP.
- Arithmetic in DATA_W+1 bits; C = bit DATA_W (borrow for SUB/SBB/CMP/DEC: C=1 when A<B etc.). ADC adds stored C; SBB subtracts stored C.
- Shifts: C = bit shifted out; ROL/ROR rotate through nothing (pure rotate), C = moved bit.
- Z = result==0; S = result MSB; V = signed overflow for ADD/ADC/SUB/SBB/CMP/INC/DEC, else 0.
- Flags updated by arithmetic, logic, shifts, MUL (Z on full product, C=V=0, S=ans_hi MSB); held by NOP/MOVB/IN/OUT/STORE. Logic ops clear C,V.
- CMP: flags only, ans_ex held. IN: ans_ex=data_in. OUT: data_out=A, ans_ex held. STORE: DM_data=B, ans_ex held. MOVB: ans_ex=B.
- NOP accepted, out_valid pulses, nothing else changes.
- in_valid during MUL_BUSY ignored (not accepted); source must hold.
- Wrap: INC of all-ones -> 0, C=1, Z=1; DEC of 0 -> all-ones, C=1.

Decomposition:
- Package exec_pkg: opcode localparams, flag bit indices, FSM state encoding.
- Sub-module seq_multiplier (DATA_W param, start/busy/done, product 2*DATA_W); remainder in exec_unit_pipe.

Test Plan:
- Reset then ADD A=8'h7F,B=8'h01 -> next cycle ans_ex=8'h80, flag_ex=4'b1100 (V,S), out_valid 1 cycle.
- ADD 8'hFF+8'h01 then ADC 8'h00+8'h00 -> ans_ex 8'h00 (C=1,Z=1), then 8'h01, C=0.
- MUL A=8'hFF,B=8'hFF -> in_ready low 8 cycles, then ans_hi=8'hFE, ans_ex=8'h01; in_valid pulses during busy not accepted.
- CMP A=8'h03,B=8'h05 -> ans_ex unchanged, C=1, S=1, Z=0; CMP equal -> Z=1.
- OUT A=8'h5A, STORE B=8'hC3, IN data_in=8'h11 -> data_out=8'h5A, DM_data=8'hC3, ans_ex=8'h11, flags held.
- reset asserted mid-MUL (cycle 4) -> next cycle all outputs 0, in_ready=1, no out_valid; DATA_W=16 rerun of ADD/MUL cases.
